// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: request/response bundle between the MEM stage and the data-memory LSU.
`default_nettype none

interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_lsu.sv
// dmem_lsu: word-addressed data memory with RV32I load/store decode, wait states and error reporting.
`default_nettype none

module dmem_lsu #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic      clk,
  input  logic      reset,
  dmem_lsu_if.slave bus
);
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ready_q;
  logic        rsp_valid_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic             w_idle;
  logic             w_we;
  logic [2:0]       w_f3;
  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic             w_commit;
  logic [31:0]      w_off;
  logic             w_range_err;
  logic             w_f3_err;
  logic             w_mis;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lane;
  logic [3:0]       w_be;
  logic [31:0]      w_wrep;
  logic [31:0]      w_word;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load;

  // With zero wait states the access commits on the accept edge, so decode the live bus.
  assign w_idle  = (state_q == S_IDLE);
  assign w_we    = w_idle ? bus.req_we     : we_q;
  assign w_f3    = w_idle ? bus.req_funct3 : f3_q;
  assign w_addr  = w_idle ? bus.req_addr   : addr_q;
  assign w_wdata = w_idle ? bus.req_wdata  : wdata_q;

  assign w_commit = !reset &&
                    ((w_idle && bus.req_valid && (WAIT_STATES == 0)) ||
                     (state_q == S_WAIT && cnt_q == 3'd0));

  // Offset is only meaningful when addr >= BASE_ADDR; the 33-bit compare cannot wrap.
  assign w_off       = w_addr - BASE_ADDR;
  assign w_range_err = (w_addr < BASE_ADDR) || ({1'b0, w_off} >= SPAN_BYTES);
  assign w_idx       = w_off[IDX_W+1:2];
  assign w_lane      = w_addr[1:0];
  assign w_f3_err    = w_we ? (w_f3 >= 3'd3)
                            : (w_f3 == 3'd3 || w_f3 == 3'd6 || w_f3 == 3'd7);
  assign w_mis       = ((w_f3[1:0] == 2'd1) && w_addr[0]) ||
                       ((w_f3[1:0] == 2'd2) && (w_addr[1:0] != 2'd0));
  assign w_err       = w_range_err || w_f3_err || w_mis;

  assign w_word = mem_q[w_idx];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load = '0;
    w_be   = 4'b1111;
    w_wrep = w_wdata;
    case (w_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = '0;
    endcase
    case (w_f3[1:0])
      2'b00: begin
        w_be   = 4'b0001 << w_lane;
        w_wrep = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{w_wdata[15:0]}};
      end
      default: begin
        w_be   = 4'b1111;
        w_wrep = w_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) mem_q[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (w_commit) begin
        rsp_valid_q <= 1'b1;
        err_q       <= w_err;
        rdata_q     <= (w_err || w_we) ? 32'h0 : w_load;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            ready_q <= 1'b0;
            if (WAIT_STATES == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 3'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 3'd0) state_q <= S_RESP;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

`default_nettype wire
